// File: rtl/rsm_pkg.sv
// Shared constants and helpers for the registered one-hot AND-OR selector.
package rsm_pkg;

  localparam int MODE_OR   = 0;
  localparam int MODE_PRIO = 1;

  // Widest hit vector the helper below can scan; callers zero-extend into it.
  localparam int MAX_LINES = 64;

  function automatic int idx_width(input int lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction

  // Index of the lowest set bit, or 0 when no bit is set.
  function automatic int lowest_set_index(input logic [MAX_LINES-1:0] vec);
    int idx;
    idx = 0;
    for (int i = MAX_LINES - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/registered_select_mux_select_core.sv
// Combinational lane selector: hit vector and lane data to one result beat.
module select_core
  import rsm_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int DATA_LINES    = 4,
  parameter int PRIORITY_MODE = MODE_OR
) (
  input  logic [DATA_WIDTH-1:0]            data_in [DATA_LINES],
  input  logic [DATA_LINES-1:0]            sel,
  output logic [DATA_WIDTH-1:0]            data,
  output logic [idx_width(DATA_LINES)-1:0] index,
  output logic                             multi_hit,
  output logic                             no_hit
);

  localparam int IDXW = idx_width(DATA_LINES);

  logic [DATA_WIDTH-1:0] masked [DATA_LINES];
  logic [DATA_WIDTH-1:0] or_data;
  logic [DATA_WIDTH-1:0] prio_data;
  int                    lowest;

  for (genvar gi = 0; gi < DATA_LINES; gi++) begin : g_mask
    assign masked[gi] = data_in[gi] & {DATA_WIDTH{sel[gi]}};
  end

  always_comb begin
    or_data   = '0;
    prio_data = '0;
    lowest    = lowest_set_index(MAX_LINES'(sel));
    for (int i = 0; i < DATA_LINES; i++) begin
      or_data = or_data | masked[i];
      // Masked lane keeps the priority result zero when nothing hits.
      if (i == lowest) prio_data = masked[i];
    end
    data      = (PRIORITY_MODE == MODE_PRIO) ? prio_data : or_data;
    index     = IDXW'(lowest);
    multi_hit = ($countones(sel) > 1);
    no_hit    = (sel == '0);
  end

endmodule

// File: rtl/registered_select_mux.sv
// Registered one-hot selector with valid/ready handshake, skid buffer and
// saturating multi-hit error counter.
module registered_select_mux
  import rsm_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int DATA_LINES    = 4,
  parameter int PRIORITY_MODE = MODE_OR,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_WIDTH-1:0]            data_in [DATA_LINES],
  input  logic [DATA_LINES-1:0]            sel,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic [idx_width(DATA_LINES)-1:0] out_index,
  output logic                             out_multi_hit,
  output logic                             out_no_hit,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ERR_CNT_WIDTH-1:0]         err_count
);

  localparam int IDXW = idx_width(DATA_LINES);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [IDXW-1:0]       index;
    logic                  multi_hit;
    logic                  no_hit;
  } beat_t;

  beat_t                    new_beat;
  beat_t                    main_reg, main_next;
  beat_t                    skid_reg, skid_next;
  logic                     main_valid_reg, main_valid_next;
  logic                     skid_valid_reg, skid_valid_next;
  logic [ERR_CNT_WIDTH-1:0] err_count_reg, err_count_next;
  logic                     accept;
  logic                     out_xfer;

  select_core #(
    .DATA_WIDTH   (DATA_WIDTH),
    .DATA_LINES   (DATA_LINES),
    .PRIORITY_MODE(PRIORITY_MODE)
  ) u_select_core (
    .data_in  (data_in),
    .sel      (sel),
    .data     (new_beat.data),
    .index    (new_beat.index),
    .multi_hit(new_beat.multi_hit),
    .no_hit   (new_beat.no_hit)
  );

  // in_ready depends only on the skid register, never on out_ready.
  assign accept   = in_valid && !skid_valid_reg;
  assign out_xfer = main_valid_reg && out_ready;

  always_comb begin
    main_next       = main_reg;
    skid_next       = skid_reg;
    main_valid_next = main_valid_reg;
    skid_valid_next = skid_valid_reg;
    err_count_next  = err_count_reg;
    if (out_xfer && skid_valid_reg) begin
      main_next       = skid_reg;
      skid_valid_next = 1'b0;
    end else if (accept && (!main_valid_reg || out_xfer)) begin
      main_next       = new_beat;
      main_valid_next = 1'b1;
    end else if (accept) begin
      skid_next       = new_beat;
      skid_valid_next = 1'b1;
    end else if (out_xfer) begin
      main_valid_next = 1'b0;
    end
    if (accept && new_beat.multi_hit && (err_count_reg != '1)) begin
      err_count_next = err_count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_reg       <= '0;
      skid_reg       <= '0;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      err_count_reg  <= '0;
    end else begin
      main_reg       <= main_next;
      skid_reg       <= skid_next;
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
      err_count_reg  <= err_count_next;
    end
  end

  assign in_ready      = !skid_valid_reg;
  assign out_valid     = main_valid_reg;
  assign data_out      = main_reg.data;
  assign out_index     = main_reg.index;
  assign out_multi_hit = main_reg.multi_hit;
  assign out_no_hit    = main_reg.no_hit;
  assign err_count     = err_count_reg;

endmodule

// File: tb/tb_registered_select_mux.sv
// Scoreboard bench: an OR-mode and a priority-mode (2-bit counter) instance
// share one stimulus stream; expected beats are queued at accept time.
module tb_registered_select_mux;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_in [4];
  logic [3:0]  sel = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_or, out_valid_or, multi_or, no_hit_or;
  logic [31:0] data_or;
  logic [1:0]  index_or;
  logic [15:0] err_or;
  logic        in_ready_pr, out_valid_pr, multi_pr, no_hit_pr;
  logic [31:0] data_pr;
  logic [1:0]  index_pr;
  logic [1:0]  err_pr;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  index;
    logic        multi_hit;
    logic        no_hit;
  } exp_t;

  exp_t q_or[$];
  exp_t q_pr[$];
  int   err_or_m = 0;
  int   err_pr_m = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  registered_select_mux #(.DATA_WIDTH(32), .DATA_LINES(4), .PRIORITY_MODE(0), .ERR_CNT_WIDTH(16)) dut_or (
    .clk(clk), .reset(reset), .data_in(data_in), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready_or), .data_out(data_or), .out_index(index_or),
    .out_multi_hit(multi_or), .out_no_hit(no_hit_or), .out_valid(out_valid_or),
    .out_ready(out_ready), .err_count(err_or)
  );

  registered_select_mux #(.DATA_WIDTH(32), .DATA_LINES(4), .PRIORITY_MODE(1), .ERR_CNT_WIDTH(2)) dut_pr (
    .clk(clk), .reset(reset), .data_in(data_in), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready_pr), .data_out(data_pr), .out_index(index_pr),
    .out_multi_hit(multi_pr), .out_no_hit(no_hit_pr), .out_valid(out_valid_pr),
    .out_ready(out_ready), .err_count(err_pr)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] s, input bit prio);
    exp_t r;
    int   cnt;
    bit   found;
    r.data = '0; r.index = '0; cnt = 0; found = 0;
    for (int i = 0; i < 4; i++) begin
      if (s[i]) begin
        cnt++;
        if (!found) begin
          found = 1;
          r.index = 2'(i);
          if (prio) r.data = data_in[i];
        end
        if (!prio) r.data = r.data | data_in[i];
      end
    end
    r.multi_hit = (cnt > 1);
    r.no_hit = (cnt == 0);
    return r;
  endfunction

  // Monitor: everything sampled at the falling edge, ahead of the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q_or.delete(); q_pr.delete();
      err_or_m = 0; err_pr_m = 0;
    end else begin
      check_eq("or_out_valid", 64'(out_valid_or), 64'(q_or.size() != 0));
      check_eq("or_in_ready", 64'(in_ready_or), 64'(q_or.size() < 2));
      check_eq("pr_out_valid", 64'(out_valid_pr), 64'(q_pr.size() != 0));
      check_eq("pr_in_ready", 64'(in_ready_pr), 64'(q_pr.size() < 2));
      check_eq("or_err_count", 64'(err_or), 64'(err_or_m));
      check_eq("pr_err_count", 64'(err_pr), 64'(err_pr_m));
      if (out_valid_or && out_ready && q_or.size() > 0) begin
        e = q_or.pop_front();
        $display("xfer or: data=%08h idx=%0d multi=%0b none=%0b", data_or, index_or, multi_or, no_hit_or);
        check_eq("or_data", 64'(data_or), 64'(e.data));
        check_eq("or_index", 64'(index_or), 64'(e.index));
        check_eq("or_multi", 64'(multi_or), 64'(e.multi_hit));
        check_eq("or_no_hit", 64'(no_hit_or), 64'(e.no_hit));
      end
      if (out_valid_pr && out_ready && q_pr.size() > 0) begin
        e = q_pr.pop_front();
        $display("xfer pr: data=%08h idx=%0d multi=%0b none=%0b", data_pr, index_pr, multi_pr, no_hit_pr);
        check_eq("pr_data", 64'(data_pr), 64'(e.data));
        check_eq("pr_index", 64'(index_pr), 64'(e.index));
        check_eq("pr_multi", 64'(multi_pr), 64'(e.multi_hit));
        check_eq("pr_no_hit", 64'(no_hit_pr), 64'(e.no_hit));
      end
      if (in_valid && in_ready_or) begin
        e = model(sel, 0);
        q_or.push_back(e);
        if (e.multi_hit && err_or_m < 65535) err_or_m++;
      end
      if (in_valid && in_ready_pr) begin
        e = model(sel, 1);
        q_pr.push_back(e);
        if (e.multi_hit && err_pr_m < 3) err_pr_m++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] s, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] d3);
    data_in[0] = d0; data_in[1] = d1; data_in[2] = d2; data_in[3] = d3;
    sel = s;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    for (int n = 0; n < 20; n++) begin
      if (in_ready_or) begin
        tick();
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    check_eq("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] s, input logic [31:0] d0, input logic [31:0] d1,
                      input logic [31:0] d2, input logic [31:0] d3);
    drive(s, d0, d1, d2, d3);
    wait_accept();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] sat_exp [5];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 4; i++) data_in[i] = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_eq("rst_out_valid", 64'(out_valid_or), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready_or), 64'd1);
    check_eq("rst_data", 64'(data_or), 64'd0);
    check_eq("rst_err", 64'(err_or), 64'd0);

    // Single hit, then latency check one cycle after accept.
    out_ready = 1'b1;
    send(4'b0100, 32'h11, 32'h22, 32'h33, 32'h44);
    check_eq("t1_out_valid", 64'(out_valid_or), 64'd1);
    check_eq("t1_data", 64'(data_or), 64'h33);
    check_eq("t1_index", 64'(index_or), 64'd2);
    check_eq("t1_err", 64'(err_or), 64'd0);
    tick();

    // Multi-hit: OR merges, priority keeps lane 0.
    send(4'b0011, 32'h0F, 32'hF0, 32'h00, 32'h00);
    check_eq("t2_or_data", 64'(data_or), 64'hFF);
    check_eq("t2_pr_data", 64'(data_pr), 64'h0F);
    check_eq("t2_multi", 64'(multi_or), 64'd1);
    check_eq("t2_err", 64'(err_or), 64'd1);
    tick();

    // No hit.
    send(4'b0000, 32'hAA, 32'hBB, 32'hCC, 32'hDD);
    check_eq("t3_data", 64'(data_pr), 64'd0);
    check_eq("t3_no_hit", 64'(no_hit_or), 64'd1);
    check_eq("t3_err", 64'(err_or), 64'd1);
    tick();

    // Random single/multi beats at full throughput.
    for (int k = 0; k < 12; k++) begin
      send(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom, $urandom);
    end
    repeat (3) tick();

    // Backpressure: A on output, B in skid, C held off.
    out_ready = 1'b0;
    send(4'b0001, 32'hA0, 32'h0, 32'h0, 32'h0);
    send(4'b0010, 32'h0, 32'hB0, 32'h0, 32'h0);
    drive(4'b1000, 32'h0, 32'h0, 32'h0, 32'hC0);
    repeat (3) begin
      tick();
      check_eq("bp_in_ready", 64'(in_ready_or), 64'd0);
      check_eq("bp_hold_data", 64'(data_or), 64'hA0);
    end
    out_ready = 1'b1;
    wait_accept();
    repeat (4) tick();

    // Reset with both entries full; the reset-cycle beat must be dropped.
    out_ready = 1'b0;
    send(4'b0110, 32'h1, 32'h2, 32'h3, 32'h4);
    send(4'b1100, 32'h5, 32'h6, 32'h7, 32'h8);
    check_eq("full_in_ready", 64'(in_ready_or), 64'd0);
    reset = 1'b1;
    drive(4'b1111, 32'h9, 32'h9, 32'h9, 32'h9);
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    check_eq("mid_rst_valid", 64'(out_valid_or), 64'd0);
    check_eq("mid_rst_ready", 64'(in_ready_pr), 64'd1);
    check_eq("mid_rst_err", 64'(err_or), 64'd0);
    check_eq("mid_rst_data", 64'(data_pr), 64'd0);
    check_eq("mid_rst_index", 64'(index_or), 64'd0);
    check_eq("mid_rst_flags", 64'({multi_or, no_hit_or}), 64'd0);

    // Saturating 2-bit counter.
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send(4'b1010, 32'h0, 32'h12, 32'h0, 32'h34);
      check_eq("sat_err", 64'(err_pr), 64'(sat_exp[k]));
    end
    repeat (4) tick();
    check_eq("drain_or", 64'(q_or.size()), 64'd0);
    check_eq("drain_pr", 64'(q_pr.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
